// File: rtl/uart_pkg.sv
// ============================================================================
//  Module      : uart_pkg
//  Description : Definitions shared by the UART transmitter and receiver:
//                frame state encoding, oversampling ratio and the width of the
//                per-bit tick counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

    // Baud ticks per bit period, as produced by the shared tick generator.
    localparam int OVERSAMPLE = 16;

    // Tick counter must reach max(OVERSAMPLE-1, SB_TICK-1); SB_TICK tops out at 32.
    localparam int TICK_CNT_W = 5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_tx_if.sv
// ============================================================================
//  Module      : uart_tx_if
//  Description : Request/status bundle between a UART transmitter and its
//                user logic.
//  Ports       : tx_start     - one-cycle request to send din
//                s_tick       - baud x16 enable pulse
//                din          - word to send
//                tx           - serial line (idles high)
//                tx_busy      - frame in progress
//                tx_done_tick - one-cycle frame-complete pulse
//  Modports    : master - user side, slave - transmitter side
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_tx_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  tx_start;
    logic                  s_tick;
    logic [DATA_WIDTH-1:0] din;
    logic                  tx;
    logic                  tx_busy;
    logic                  tx_done_tick;

    modport master (
        output tx_start,
        output s_tick,
        output din,
        input  tx,
        input  tx_busy,
        input  tx_done_tick
    );

    modport slave (
        input  tx_start,
        input  s_tick,
        input  din,
        output tx,
        output tx_busy,
        output tx_done_tick
    );
endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
//  Module      : uart_tx
//  Description : UART serial transmitter. Serialises a parallel word LSB first
//                as start bit, DATA_WIDTH data bits, optional even parity bit
//                and SB_TICK ticks of stop, timed by an external x16 baud tick.
//  Parameters  : DATA_WIDTH - data bits per frame (5..8)
//                SB_TICK    - ticks in stop period (16/24/32 = 1/1.5/2 bits)
//  Ports       : clk   - system clock
//                reset - synchronous, active-high reset
//                bus   - uart_tx_if.slave (tx_start, s_tick, din, tx,
//                        tx_busy, tx_done_tick)
//  Macros      : UART_TX_PARITY_EN - adds an even parity bit after the data
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SB_TICK    = 16
) (
    input  wire logic   clk,
    input  wire logic   reset,
    uart_tx_if.slave    bus
);

    localparam logic [TICK_CNT_W-1:0] c_bit_last  = TICK_CNT_W'(OVERSAMPLE - 1);
    localparam logic [TICK_CNT_W-1:0] c_stop_last = TICK_CNT_W'(SB_TICK - 1);
    localparam logic [2:0]            c_data_last = 3'(DATA_WIDTH - 1);

    uart_state_t             r_state, w_state_next;
    logic [TICK_CNT_W-1:0]   r_s, w_s_next;
    logic [2:0]              r_n, w_n_next;
    logic [DATA_WIDTH-1:0]   r_b, w_b_next;
    logic                    r_tx, w_tx_next;
    logic                    r_busy;
    logic                    r_done, w_done_next;
`ifdef UART_TX_PARITY_EN
    logic                    r_par, w_par_next;
`endif

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_done_next  = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_next   = r_par;
`endif

        case (r_state)
            ST_IDLE: begin
                // Acceptance does not wait for a tick; the start bit begins
                // on the accepting edge.
                if (bus.tx_start) begin
                    w_b_next     = bus.din;
                    w_s_next     = '0;
                    w_state_next = ST_START;
`ifdef UART_TX_PARITY_EN
                    w_par_next   = ^bus.din;
`endif
                end
            end

            ST_START: begin
                if (bus.s_tick) begin
                    if (r_s == c_bit_last) begin
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_state_next = ST_DATA;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end

            ST_DATA: begin
                if (bus.s_tick) begin
                    if (r_s == c_bit_last) begin
                        w_s_next = '0;
                        w_b_next = r_b >> 1;
                        if (r_n == c_data_last) begin
`ifdef UART_TX_PARITY_EN
                            w_state_next = ST_PARITY;
`else
                            w_state_next = ST_STOP;
`endif
                        end else begin
                            w_n_next = r_n + 1'b1;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end

`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bus.s_tick) begin
                    if (r_s == c_bit_last) begin
                        w_s_next     = '0;
                        w_state_next = ST_STOP;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
`endif

            ST_STOP: begin
                if (bus.s_tick) begin
                    if (r_s == c_stop_last) begin
                        w_state_next = ST_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // The line level is a function of the state being entered, so it can
        // be registered alongside the state with no input-to-tx path.
        w_tx_next = 1'b1;
        case (w_state_next)
            ST_START:  w_tx_next = 1'b0;
            ST_DATA:   w_tx_next = w_b_next[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_tx_next = w_par_next;
`endif
            default:   w_tx_next = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
            r_tx    <= w_tx_next;
            r_busy  <= (w_state_next != ST_IDLE);
            r_done  <= w_done_next;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par_next;
`endif
        end
    end

    assign bus.tx           = r_tx;
    assign bus.tx_busy      = r_busy;
    assign bus.tx_done_tick = r_done;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Self-checking bench for uart_tx. Two transmitters (1 and 2
//                stop bits) share one stimulus stream; a frame-segment model
//                predicts tx/tx_busy/tx_done_tick every cycle and directed
//                sequences pin decoded words, lengths and edge cases.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int NSEG = 2 + DW + PAR_BITS;

    logic          clk      = 1'b0;
    logic          reset    = 1'b1;
    logic          tx_start = 1'b0;
    logic          s_tick   = 1'b0;
    logic [DW-1:0] din      = '0;

    int  tick_period = 1;
    int  tick_phase  = 0;
    bit  chk_en      = 1'b0;
    int  checks      = 0;
    int  errors      = 0;
    int  fail_prints = 0;
    int  done_cnt [2] = '{0, 0};

    always #5 clk = ~clk;

    uart_tx_if #(.DATA_WIDTH(DW)) bus0 ();
    uart_tx_if #(.DATA_WIDTH(DW)) bus1 ();

    assign bus0.tx_start = tx_start;
    assign bus0.s_tick   = s_tick;
    assign bus0.din      = din;
    assign bus1.tx_start = tx_start;
    assign bus1.s_tick   = s_tick;
    assign bus1.din      = din;

    uart_tx #(.DATA_WIDTH(DW), .SB_TICK(16)) dut0 (.clk(clk), .reset(reset), .bus(bus0));
    uart_tx #(.DATA_WIDTH(DW), .SB_TICK(32)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (fail_prints < 40) begin
                fail_prints++;
                $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
            end
        end
    endtask

    // Baud tick source: one-clk pulse every tick_period clocks.
    always @(negedge clk) begin
        s_tick = (tick_phase == 0);
        tick_phase = (tick_phase + 1 >= tick_period) ? 0 : tick_phase + 1;
    end

    // Completed-frame counters (sampled before the DUT registers update).
    always @(posedge clk) begin
        if (bus0.tx_done_tick === 1'b1) done_cnt[0]++;
        if (bus1.tx_done_tick === 1'b1) done_cnt[1]++;
    end

    // ------------------------------------------------------------------
    // Frame model: a frame is a list of (level, tick-length) segments.
    // ------------------------------------------------------------------
    int   sbt [2] = '{16, 32};
    logic m_lvl [2][NSEG];
    int   m_len [2][NSEG];
    int   m_seg [2] = '{0, 0};
    int   m_cnt [2] = '{0, 0};
    bit   m_act [2] = '{0, 0};
    logic exp_tx   [2] = '{1'b1, 1'b1};
    logic exp_busy [2] = '{1'b0, 1'b0};
    logic exp_done [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_done[k] = 1'b0;
            if (reset) begin
                m_act[k] = 1'b0;
            end else if (!m_act[k]) begin
                if (tx_start) begin
                    m_lvl[k][0] = 1'b0;
                    m_len[k][0] = 16;
                    for (int i = 0; i < DW; i++) begin
                        m_lvl[k][1+i] = din[i];
                        m_len[k][1+i] = 16;
                    end
                    if (PAR_BITS == 1) begin
                        m_lvl[k][1+DW] = ^din;
                        m_len[k][1+DW] = 16;
                    end
                    m_lvl[k][NSEG-1] = 1'b1;
                    m_len[k][NSEG-1] = sbt[k];
                    m_act[k] = 1'b1;
                    m_seg[k] = 0;
                    m_cnt[k] = 0;
                end
            end else if (s_tick) begin
                m_cnt[k]++;
                if (m_cnt[k] == m_len[k][m_seg[k]]) begin
                    m_cnt[k] = 0;
                    m_seg[k]++;
                    if (m_seg[k] == NSEG) begin
                        m_act[k]    = 1'b0;
                        exp_done[k] = 1'b1;
                    end
                end
            end
            exp_tx[k]   = m_act[k] ? m_lvl[k][m_seg[k]] : 1'b1;
            exp_busy[k] = m_act[k];
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("tx0",   32'(bus0.tx),           32'(exp_tx[0]));
            check("busy0", 32'(bus0.tx_busy),      32'(exp_busy[0]));
            check("done0", 32'(bus0.tx_done_tick), 32'(exp_done[0]));
            check("tx1",   32'(bus1.tx),           32'(exp_tx[1]));
            check("busy1", 32'(bus1.tx_busy),      32'(exp_busy[1]));
            check("done1", 32'(bus1.tx_done_tick), 32'(exp_done[1]));
        end
    end

    // Called at a negedge with tx_start already raised; returns at the first
    // negedge where dut0 is no longer busy (its tx_done_tick cycle).
    task automatic capture(input bit mid_en, input logic [DW-1:0] mid_d,
                           output logic [DW-1:0] w, output logic pbit,
                           output logic first_tx, output logic first_busy,
                           output int blen, output bit timed_out);
        w = '0; pbit = 1'b0; first_tx = 1'bx; first_busy = 1'bx;
        blen = 0; timed_out = 1'b1;
        for (int j = 1; j <= 400; j++) begin
            @(negedge clk);
            if (j == 1) begin
                tx_start   = 1'b0;
                first_tx   = bus0.tx;
                first_busy = bus0.tx_busy;
            end
            if (mid_en && j == 40) begin tx_start = 1'b1; din = mid_d; end
            if (mid_en && j == 41) tx_start = 1'b0;
            for (int i = 0; i < DW; i++)
                if (j == 8 + 16 * (i + 1)) w[i] = bus0.tx;
            if (j == 8 + 16 * (DW + 1)) pbit = bus0.tx;
            if (bus0.tx_busy === 1'b1) blen++;
            else begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        logic [DW-1:0] w;
        logic p, ftx, fbusy;
        int   bl, hi0, hi1, snap;
        bit   to;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b0;

        // Idle after reset
        repeat (50) @(negedge clk);
        check("idle_tx",   32'(bus0.tx), 32'd1);
        check("idle_busy", 32'(bus0.tx_busy), 32'd0);
        check("idle_done_cnt", 32'(done_cnt[0]), 32'd0);

        // Basic 0x55 frame, tick every clk
        din = 8'h55; tx_start = 1'b1;
        capture(1'b0, '0, w, p, ftx, fbusy, bl, to);
        check("b55_timeout", 32'(to), 32'd0);
        check("b55_start_lat", 32'(ftx), 32'd0);
        check("b55_busy_lat", 32'(fbusy), 32'd1);
        check("b55_word", 32'(w), 32'h55);
        check("b55_after_data", 32'(p), (PAR_BITS == 1) ? 32'd0 : 32'd1);
        check("b55_busy_len", 32'(bl), 32'(160 + 16 * PAR_BITS));
        check("b55_done_pulse", 32'(bus0.tx_done_tick), 32'd1);
        repeat (40) @(negedge clk);
        check("b55_frames0", 32'(done_cnt[0]), 32'd1);
        check("b55_frames1", 32'(done_cnt[1]), 32'd1);

        // 0xA3 with a 0xFF request mid-frame, then 0x3C back-to-back
        din = 8'hA3; tx_start = 1'b1;
        capture(1'b1, 8'hFF, w, p, ftx, fbusy, bl, to);
        check("a3_timeout", 32'(to), 32'd0);
        check("a3_word", 32'(w), 32'hA3);
        check("a3_done_pulse", 32'(bus0.tx_done_tick), 32'd1);
        din = 8'h3C; tx_start = 1'b1;
        capture(1'b0, '0, w, p, ftx, fbusy, bl, to);
        check("b2b_timeout", 32'(to), 32'd0);
        check("b2b_no_idle_bit", 32'(ftx), 32'd0);
        check("b2b_busy", 32'(fbusy), 32'd1);
        check("b2b_word", 32'(w), 32'h3C);
        repeat (40) @(negedge clk);
        check("b2b_frames0", 32'(done_cnt[0]), 32'd3);
        check("b2b_frames1", 32'(done_cnt[1]), 32'd2);

        // Sparse ticks, stop period length on both stop settings
        tick_period = 4;
        din = 8'h00; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        hi0 = 0; hi1 = 0; to = 1'b1;
        for (int j = 0; j < 2000; j++) begin
            if (bus0.tx_busy === 1'b1 && bus0.tx === 1'b1) hi0++;
            if (bus1.tx_busy === 1'b1 && bus1.tx === 1'b1) hi1++;
            if (bus0.tx_busy !== 1'b1 && bus1.tx_busy !== 1'b1) begin
                to = 1'b0;
                break;
            end
            @(negedge clk);
        end
        check("sparse_timeout", 32'(to), 32'd0);
        check("stop_len_sb16", 32'(hi0), 32'd64 + 32'(64 * PAR_BITS * 0));
        check("stop_len_sb32", 32'(hi1), 32'd128);
        tick_period = 1;
        repeat (40) @(negedge clk);

        // Reset during data bit 3 of 0x0F
        din = 8'h0F; tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (69) @(negedge clk);
        snap = done_cnt[0];
        reset = 1'b1;
        @(negedge clk);
        check("rst_tx", 32'(bus0.tx), 32'd1);
        check("rst_busy", 32'(bus0.tx_busy), 32'd0);
        reset = 1'b0;
        repeat (200) @(negedge clk);
        check("rst_no_done", 32'(done_cnt[0]), 32'(snap));
        din = 8'h81; tx_start = 1'b1;
        capture(1'b0, '0, w, p, ftx, fbusy, bl, to);
        check("r81_timeout", 32'(to), 32'd0);
        check("r81_word", 32'(w), 32'h81);
        check("r81_busy_len", 32'(bl), 32'(160 + 16 * PAR_BITS));
        repeat (40) @(negedge clk);

`ifdef UART_TX_PARITY_EN
        din = 8'h07; tx_start = 1'b1;
        capture(1'b0, '0, w, p, ftx, fbusy, bl, to);
        check("p07_word", 32'(w), 32'h07);
        check("p07_parity", 32'(p), 32'd1);
        check("p07_busy_len", 32'(bl), 32'd176);
        repeat (40) @(negedge clk);
`endif

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, actual running required finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- UART serial transmitter; partner to the existing 16x-oversampled UART receiver in the same interface IP.
- Accepts a parallel word on a one-cycle start strobe and serialises it LSB-first: start bit, DATA_WIDTH data bits, optional parity bit, stop bit(s).
- Timing comes from the shared external baud tick generator (s_tick, 16 ticks per bit), the same one that drives the receiver.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..8).
- SB_TICK, 16, s_ticks in the stop period (16 = 1 stop bit, 24 = 1.5, 32 = 2).

Ports:
- clk  in  1  system clock.
- reset  in  1  reset; synchronous and active-high.
- tx_start  in  1  one-cycle request to send din.
- s_tick  in  1  baud x16 enable pulse, one clk wide.
- din  in  DATA_WIDTH  word to send; sampled only when a request is accepted.
- tx  out  1  serial line, registered; idles high.
- tx_busy  out  1  high from acceptance until return to IDLE.
- tx_done_tick  out  1  one-clk pulse when a frame completes.

Behaviour:
- Reset values (clk edge with reset=1): state=IDLE, tx=1, tx_busy=0, tx_done_tick=0, counters=0, shift register=0.
- Reset mid-frame abandons the frame; tx goes to 1 at that same edge.
- Counters:
  - s: 5-bit tick counter, range 0..max(15, SB_TICK-1).
  - n: 3-bit data-bit counter.
  - b: DATA_WIDTH shift register.
- States:
  - IDLE: tx=1. If tx_start=1 at a clk edge: b<=din, s<=0, go START. tx=0 and tx_busy=1 from that same edge (latency 1 clk). s_tick is not needed to accept.
  - START: tx=0. On each s_tick: if s==15 then s<=0, n<=0, go DATA; else s<=s+1.
  - DATA: tx=b[0]. On each s_tick with s==15: s<=0, b<=b>>1. If n==DATA_WIDTH-1, go STOP (or PARITY when enabled); else n<=n+1. On other s_ticks: s<=s+1.
  - STOP: tx=1. On each s_tick: if s==SB_TICK-1 then go IDLE, tx_busy<=0, tx_done_tick<=1 for exactly one clk; else s<=s+1.
- Timing: each bit lasts exactly 16 s_ticks; the stop period lasts SB_TICK s_ticks. Without s_tick, state and tx hold.
- tx_start while tx_busy=1 is ignored. din is not re-sampled and the frame is not corrupted.
- tx_start in the same cycle tx_done_tick=1: state is already IDLE, so it is accepted, giving back-to-back frames with no extra idle bit.
- tx is driven from a register; no combinational path from any input to tx.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Even parity p = XOR of din, captured at acceptance.
  - DATA moves to a PARITY state: tx=p for 16 s_ticks, then STOP.
  - Frame is 1 + DATA_WIDTH + 1 bits + stop.
- Undefined: no PARITY state; DATA goes directly to STOP; no parity register.

Decomposition:
- Shared package uart_pkg:
  - state encoding IDLE/START/DATA/PARITY/STOP, 3-bit;
  - OVERSAMPLE=16;
  - tick-counter width constant.
- The receiver uses the same package.
- No sub-module; the baud tick generator stays external and shared. A single module with a registered-state/next-state pair is sufficient.

Test Plan:
- Reset idle: reset for 3 clks, then 50 clks with no start -> tx=1, tx_busy=0, tx_done_tick=0 throughout.
- Basic frame: s_tick every clk, din=0x55, one-clk tx_start -> tx sequence 0,1,0,1,0,1,0,1,0,1 with each bit exactly 16 clks; tx_done_tick pulses once, 160 clks after acceptance; tx_busy is high for exactly those 160 clks.
- Busy ignore and back-to-back:
  - Send 0xA3 and pulse tx_start with din=0xFF mid-frame -> received word 0xA3 and only one frame.
  - Then assert tx_start with din=0x3C in the tx_done_tick cycle -> 0x3C frame starts on the next edge with no idle bit.
- Stop length and sparse ticks: SB_TICK=32, s_tick every 4 clks, din=0x00 -> stop period is 128 clks; tx holds value between ticks.
- Reset mid-frame: assert reset during data bit 3 of 0x0F -> tx=1 and tx_busy=0 after that edge, and no tx_done_tick. A subsequent 0x81 frame is sent correctly.
- Parity (UART_TX_PARITY_EN defined): din=0x07 -> parity bit 1; din=0x55 -> parity bit 0; frame length is 176 clks with s_tick every clk.
